decode_branch_stage: RTL and testbench
======================================

# decode_branch_stage

IF/ID pipeline register and decode-stage branch resolution for the 32-bit MIPS pipeline. It sits directly downstream of instruction fetch and captures the fetched instruction and PC+4 each cycle. It resolves `beq` (and optionally `bne`) in decode using forwarded operands. It returns `PCbranchD`/`PCSrcD` to fetch and inserts a bubble on a taken branch.

## Interface
Parameters:
- `NOP_WORD`, default 32'h0000_0000, encoding loaded into `instrD` on reset or flush.
- `CNT_W`, default 16, width of the saturating bubble counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous and active-high.
- `instrF` in 32: instruction from fetch.
- `pcPlus4F` in 32: PC+4 of `instrF`.
- `stallD` in 1: hazard unit request to hold IF/ID.
- `rd1D` in 32: register-file read data for rs.
- `rd2D` in 32: register-file read data for rt.
- `aluOutM` in 32: memory-stage ALU result for forwarding.
- `forwardAD` in 1: use `aluOutM` instead of `rd1D`.
- `forwardBD` in 1: use `aluOutM` instead of `rd2D`.
- `instrD` out 32: registered instruction.
- `pcPlus4D` out 32: registered PC+4.
- `validD` out 1: `instrD` is a real instruction (0 = bubble).
- `rsD` out 5: `instrD[25:21]`.
- `rtD` out 5: `instrD[20:16]`.
- `rdD` out 5: `instrD[15:11]`.
- `branchD` out 1: valid branch opcode in decode.
- `PCbranchD` out 32: branch target.
- `PCSrcD` out 1: take the branch.
- `bubbleCount` out CNT_W: number of flush bubbles inserted, saturating.

## Operation
- Pipeline register update on each posedge, by priority:
  - `PCSrcD`=1 (flush): `instrD`←NOP_WORD, `pcPlus4D`←`pcPlus4F`, `validD`←0.
  - `stallD`=1: all registers hold.
  - Otherwise: `instrD`←`instrF`, `pcPlus4D`←`pcPlus4F`, `validD`←1.
- Flush vs stall: `PCSrcD` is gated by `~stallD`, so flush and stall never act together.
- Operand select:
  - `srcA` = `forwardAD` ? `aluOutM` : `rd1D`.
  - `srcB` = `forwardBD` ? `aluOutM` : `rd2D`.
- `eqD` = (`srcA` == `srcB`), full 32-bit compare.
- `branchD` = `validD` & (opcode `instrD[31:26]` == 6'b000100).
- `PCSrcD` = `branchD` & `eqD` & ~`stallD`.
- `PCbranchD` = `pcPlus4D` + {{14{instrD[15]}}, instrD[15:0], 2'b00}:
  - addition is mod 2^32; wrap-around is silent;
  - output is driven whether or not a branch is present.
- `bubbleCount` increments by 1 on each flush edge and saturates at all-ones.
- Reset values:
  - `instrD`=NOP_WORD, `pcPlus4D`=0, `validD`=0, `bubbleCount`=0.
  - Hence `branchD`=0 and `PCSrcD`=0.
  - `PCbranchD`=32'h0000_0000 while `instrD`=NOP_WORD.

## Timing
- IF→D latency is 1 cycle: a word on `instrF` at edge N appears on `instrD` after edge N.
- `PCSrcD`, `PCbranchD`, `branchD` and the `rsD`/`rtD`/`rdD` fields are combinational from registered state plus same-cycle forwarding inputs, with no extra cycle.
- Fetch samples `PCSrcD` at the same edge where this block captures the bubble. The wrong-path word in IF is discarded, and the target is fetched next.
- Exactly one bubble per taken branch, with no delay slot.
- `rst` asserted mid-operation clears state immediately, not on the next edge. The first capture occurs on the first posedge after `rst` deasserts.
- While `stallD`=1, outputs stay stable across edges, and `bubbleCount` does not change.

## Configuration
- `DECODE_BNE_EN` defined:
  - `branchD` also asserts for opcode 6'b000101.
  - For that opcode, `PCSrcD` = `branchD` & ~`eqD` & ~`stallD`.
- Undefined: opcode 000101 is not a branch here; `branchD`=0 and `PCSrcD`=0 for it.

## Test plan
- Reset then run:
  - Assert `rst` mid-cycle, then drive `instrF`=32'h2008_0005, `pcPlus4F`=4 for one edge.
  - Required: outputs 0/NOP asynchronously during reset; after one edge `instrD`=32'h2008_0005, `validD`=1, `rsD`=0, `rtD`=8.
- Taken beq:
  - `instrD`=32'h1085_0003, `pcPlus4D`=32'h40, `rd1D`=`rd2D`=7.
  - Required: `PCSrcD`=1 and `PCbranchD`=32'h4C.
  - Next edge: `instrD`=NOP, `validD`=0, `bubbleCount`=1.
- Not-taken and forwarding:
  - `rd1D`=7, `rd2D`=9: required `PCSrcD`=0.
  - Then `forwardBD`=1, `aluOutM`=7: required `PCSrcD`=1.
- Stall:
  - `stallD`=1 for 3 edges with a taken-branch condition present.
  - Required: `PCSrcD`=0, and `instrD`/`pcPlus4D`/`bubbleCount` unchanged.
  - After `stallD` falls: `PCSrcD`=1.
- Negative offset and wrap:
  - imm=16'hFFFF, `pcPlus4D`=32'h40: required `PCbranchD`=32'h3C.
  - imm=16'hFFFF, `pcPlus4D`=0: required `PCbranchD`=32'hFFFF_FFFC.
- bne and saturation:
  - opcode 000101 with unequal operands: `PCSrcD`=1 only with `DECODE_BNE_EN` defined.
  - `CNT_W`=2 with 5 flushes: required `bubbleCount`=3.

Source files
------------

// File: rtl/decode_branch_stage_if.sv
// rtl/decode_branch_stage_if.sv - fetch/forwarding inputs and decode outputs of the IF/ID branch stage
interface decode_branch_stage_if #(
  parameter int CNT_W = 16
);
  // Fetch side
  logic [31:0]      instrF;
  logic [31:0]      pcPlus4F;
  // Hazard unit and forwarding
  logic             stallD;
  logic [31:0]      rd1D;
  logic [31:0]      rd2D;
  logic [31:0]      aluOutM;
  logic             forwardAD;
  logic             forwardBD;
  // Decode outputs
  logic [31:0]      instrD;
  logic [31:0]      pcPlus4D;
  logic             validD;
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic [4:0]       rdD;
  logic             branchD;
  logic [31:0]      PCbranchD;
  logic             PCSrcD;
  logic [CNT_W-1:0] bubbleCount;

  // Pipeline neighbours: drive fetch/forwarding, observe decode
  modport master (
    output instrF, pcPlus4F, stallD, rd1D, rd2D, aluOutM, forwardAD, forwardBD,
    input  instrD, pcPlus4D, validD, rsD, rtD, rdD, branchD, PCbranchD, PCSrcD,
           bubbleCount
  );

  // The decode stage itself
  modport slave (
    input  instrF, pcPlus4F, stallD, rd1D, rd2D, aluOutM, forwardAD, forwardBD,
    output instrD, pcPlus4D, validD, rsD, rtD, rdD, branchD, PCbranchD, PCSrcD,
           bubbleCount
  );
endinterface

// File: rtl/decode_branch_stage.sv
// rtl/decode_branch_stage.sv - IF/ID register with decode-stage beq resolution (bne when DECODE_BNE_EN is defined)
module decode_branch_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst,
  decode_branch_stage_if.slave dif
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic [31:0]      instr_q;
  logic [31:0]      pc_plus4_q;
  logic             valid_q;
  logic [CNT_W-1:0] bubble_q;

  logic [31:0]      src_a;
  logic [31:0]      src_b;
  logic             eq;
  logic [5:0]       opcode;
  logic             is_beq;
  logic             is_bne;
  logic             take;
  logic [31:0]      br_offset;

  // Same-cycle operand selection, comparison and branch decision from the registered instruction
  always_comb begin
    src_a     = dif.forwardAD ? dif.aluOutM : dif.rd1D;
    src_b     = dif.forwardBD ? dif.aluOutM : dif.rd2D;
    eq        = (src_a == src_b);
    opcode    = instr_q[31:26];
    is_beq    = valid_q && (opcode == OP_BEQ);
`ifdef DECODE_BNE_EN
    is_bne    = valid_q && (opcode == OP_BNE);
`else
    is_bne    = 1'b0;
`endif
    // Stall suppresses the redirect so a held branch never flushes twice or early
    take      = ((is_beq && eq) || (is_bne && !eq)) && !dif.stallD;
    br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  end

  // IF/ID register: flush beats stall, stall beats capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else if (take) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= dif.pcPlus4F;
      valid_q    <= 1'b0;
    end else if (!dif.stallD) begin
      instr_q    <= dif.instrF;
      pc_plus4_q <= dif.pcPlus4F;
      valid_q    <= 1'b1;
    end
  end

  // Saturating count of bubbles inserted by taken branches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_q <= '0;
    end else if (take && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign dif.instrD      = instr_q;
  assign dif.pcPlus4D    = pc_plus4_q;
  assign dif.validD      = valid_q;
  assign dif.rsD         = instr_q[25:21];
  assign dif.rtD         = instr_q[20:16];
  assign dif.rdD         = instr_q[15:11];
  assign dif.branchD     = is_beq || is_bne;
  assign dif.PCSrcD      = take;
  // Target is always driven; wrap-around past 2^32 is intentional
  assign dif.PCbranchD   = pc_plus4_q + br_offset;
  assign dif.bubbleCount = bubble_q;

endmodule

// File: tb/tb_decode_branch_stage.sv
// tb/tb_decode_branch_stage.sv - vector table plus hand sequences for decode_branch_stage
module tb_decode_branch_stage;

`ifdef DECODE_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  localparam logic [15:0] C7 = BNE_ON ? 16'd2 : 16'd1;
  localparam logic [15:0] C9 = C7 + 16'd1;

  typedef struct {
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic        stall;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] alu;
    logic        fa;
    logic        fb;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [4:0]  e_rd;
    logic        e_br;
    logic        e_src;
    logic [31:0] e_tgt;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 11;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  vec_t vecs [NV];
  vec_t sb [$];
  vec_t e;

  decode_branch_stage_if #(.CNT_W(16)) if1 ();
  decode_branch_stage_if #(.CNT_W(2))  if2 ();

  decode_branch_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .dif (if1)
  );

  decode_branch_stage #(.NOP_WORD(32'h0000_0000), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .dif (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic [31:0] instr_f, input logic [31:0] pc_f, input logic stall,
                        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] alu,
                        input logic fa, input logic fb);
    if1.instrF    = instr_f;
    if1.pcPlus4F  = pc_f;
    if1.stallD    = stall;
    if1.rd1D      = rd1;
    if1.rd2D      = rd2;
    if1.aluOutM   = alu;
    if1.forwardAD = fa;
    if1.forwardBD = fb;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b0;
    drive1(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    if2.instrF    = 32'h1000_0000;
    if2.pcPlus4F  = 32'h0;
    if2.stallD    = 1'b1;
    if2.rd1D      = 32'h0;
    if2.rd2D      = 32'h0;
    if2.aluOutM   = 32'h0;
    if2.forwardAD = 1'b0;
    if2.forwardBD = 1'b0;

    //            instrF        pcF    st rd1  rd2  alu fa fb  e_instr       e_pc   v  rs rt rd  br src  tgt            cnt
    vecs[0]  = '{32'h2008_0005, 32'h04, 0, 0,   0,   0,  0, 0, 32'h2008_0005, 32'h04, 1, 0, 8, 0,  0, 0,   32'h18,        16'd0};
    vecs[1]  = '{32'h1085_0003, 32'h40, 0, 7,   7,   0,  0, 0, 32'h1085_0003, 32'h40, 1, 4, 5, 0,  1, 1,   32'h4C,        16'd0};
    vecs[2]  = '{32'hDEAD_BEEF, 32'h44, 0, 7,   7,   0,  0, 0, 32'h0000_0000, 32'h44, 0, 0, 0, 0,  0, 0,   32'h44,        16'd1};
    vecs[3]  = '{32'h1085_0003, 32'h50, 0, 7,   9,   0,  0, 0, 32'h1085_0003, 32'h50, 1, 4, 5, 0,  1, 0,   32'h5C,        16'd1};
    vecs[4]  = '{32'h1000_FFFF, 32'h40, 0, 7,   9,   0,  0, 0, 32'h1000_FFFF, 32'h40, 1, 0, 0, 31, 1, 0,   32'h3C,        16'd1};
    vecs[5]  = '{32'h1000_FFFF, 32'h00, 0, 7,   9,   0,  0, 0, 32'h1000_FFFF, 32'h00, 1, 0, 0, 31, 1, 0,   32'hFFFF_FFFC, 16'd1};
    vecs[6]  = '{32'h1400_0002, 32'h60, 0, 1,   2,   0,  0, 0, 32'h1400_0002, 32'h60, 1, 0, 0, 0,  BNE_ON, BNE_ON, 32'h68, 16'd1};
    vecs[7]  = '{32'h0000_0000, 32'h64, 0, 1,   2,   0,  0, 0, 32'h0000_0000, 32'h64, !BNE_ON, 0, 0, 0, 0, 0, 32'h64, C7};
    vecs[8]  = '{32'h1085_0003, 32'h70, 0, 3,   5,   5,  1, 0, 32'h1085_0003, 32'h70, 1, 4, 5, 0,  1, 1,   32'h7C,        C7};
    vecs[9]  = '{32'h1234_5678, 32'h74, 0, 3,   5,   5,  1, 0, 32'h0000_0000, 32'h74, 0, 0, 0, 0,  0, 0,   32'h74,        C9};
    vecs[10] = '{32'h1085_0003, 32'h80, 0, 7,   7,   0,  0, 0, 32'h1085_0003, 32'h80, 1, 4, 5, 0,  1, 1,   32'h8C,        C9};

    // Asynchronous reset at power-up, before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("por_instrD", if1.instrD, 32'h0);
    chk("por_pcPlus4D", if1.pcPlus4D, 32'h0);
    chk("por_validD", {31'b0, if1.validD}, 32'h0);
    chk("por_PCSrcD", {31'b0, if1.PCSrcD}, 32'h0);
    chk("por_PCbranchD", if1.PCbranchD, 32'h0);
    chk("por_bubbleCount", {16'b0, if1.bubbleCount}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: drive before the edge, compare after it
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive1(vecs[i].instr_f, vecs[i].pc_f, vecs[i].stall, vecs[i].rd1, vecs[i].rd2,
             vecs[i].alu, vecs[i].fa, vecs[i].fb);
      sb.push_back(vecs[i]);
      @(posedge clk);
      #2;
      e = sb.pop_front();
      chk($sformatf("v%0d_instrD", i), if1.instrD, e.e_instr);
      chk($sformatf("v%0d_pcPlus4D", i), if1.pcPlus4D, e.e_pc);
      chk($sformatf("v%0d_validD", i), {31'b0, if1.validD}, {31'b0, e.e_valid});
      chk($sformatf("v%0d_rsD", i), {27'b0, if1.rsD}, {27'b0, e.e_rs});
      chk($sformatf("v%0d_rtD", i), {27'b0, if1.rtD}, {27'b0, e.e_rt});
      chk($sformatf("v%0d_rdD", i), {27'b0, if1.rdD}, {27'b0, e.e_rd});
      chk($sformatf("v%0d_branchD", i), {31'b0, if1.branchD}, {31'b0, e.e_br});
      chk($sformatf("v%0d_PCSrcD", i), {31'b0, if1.PCSrcD}, {31'b0, e.e_src});
      chk($sformatf("v%0d_PCbranchD", i), if1.PCbranchD, e.e_tgt);
      chk($sformatf("v%0d_bubbleCount", i), {16'b0, if1.bubbleCount}, {16'b0, e.e_cnt});
    end

    // Stall with a taken beq held in decode
    @(negedge clk);
    drive1(32'hAAAA_AAAA, 32'h84, 1'b1, 32'd7, 32'd7, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stall_PCSrcD_gated", {31'b0, if1.PCSrcD}, 32'h0);
    chk("stall_branchD", {31'b0, if1.branchD}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
      chk($sformatf("stall%0d_instrD", k), if1.instrD, 32'h1085_0003);
      chk($sformatf("stall%0d_pcPlus4D", k), if1.pcPlus4D, 32'h80);
      chk($sformatf("stall%0d_bubbleCount", k), {16'b0, if1.bubbleCount}, {16'b0, C9});
      chk($sformatf("stall%0d_PCSrcD", k), {31'b0, if1.PCSrcD}, 32'h0);
    end
    @(negedge clk);
    if1.stallD = 1'b0;
    #1;
    chk("unstall_PCSrcD", {31'b0, if1.PCSrcD}, 32'h1);
    @(posedge clk);
    #2;
    chk("unstall_flush_instrD", if1.instrD, 32'h0);
    chk("unstall_flush_validD", {31'b0, if1.validD}, 32'h0);
    chk("unstall_flush_pcPlus4D", if1.pcPlus4D, 32'h84);
    chk("unstall_flush_bubbleCount", {16'b0, if1.bubbleCount}, {16'b0, C9 + 16'd1});

    // Not taken, then taken purely through forwarding of rt
    @(negedge clk);
    drive1(32'h1085_0003, 32'h90, 1'b0, 32'd7, 32'd9, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("fwd_nottaken_PCSrcD", {31'b0, if1.PCSrcD}, 32'h0);
    if1.aluOutM   = 32'd7;
    if1.forwardBD = 1'b1;
    #1;
    chk("fwd_taken_PCSrcD", {31'b0, if1.PCSrcD}, 32'h1);
    chk("fwd_taken_PCbranchD", if1.PCbranchD, 32'h9C);

    // Mid-cycle reset clears state without a clock edge
    rst = 1'b1;
    #1;
    chk("rst_instrD", if1.instrD, 32'h0);
    chk("rst_validD", {31'b0, if1.validD}, 32'h0);
    chk("rst_pcPlus4D", if1.pcPlus4D, 32'h0);
    chk("rst_bubbleCount", {16'b0, if1.bubbleCount}, 32'h0);
    chk("rst_PCSrcD", {31'b0, if1.PCSrcD}, 32'h0);
    chk("rst_branchD", {31'b0, if1.branchD}, 32'h0);
    chk("rst_PCbranchD", if1.PCbranchD, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive1(32'h2008_0005, 32'h04, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("post_rst_instrD", if1.instrD, 32'h2008_0005);
    chk("post_rst_validD", {31'b0, if1.validD}, 32'h1);
    chk("post_rst_rsD", {27'b0, if1.rsD}, 32'd0);
    chk("post_rst_rtD", {27'b0, if1.rtD}, 32'd8);

    // 2-bit counter: a beq with equal operands flushes every second edge
    @(negedge clk);
    if2.stallD = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #2;
      chk($sformatf("sat_edge%0d", k), {30'b0, if2.bubbleCount},
          (k / 2 > 3) ? 32'd3 : 32'(k / 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
